// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and fetch FSM state encoding
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response bus
interface fetch_stage_if #(parameter int N = 32);

    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_rdata;
    logic         imem_rvalid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_rvalid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_rvalid);

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry holding register for a response IF/ID cannot take yet
module fetch_buffer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         valid
);

    logic [N-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    // clear wins over load so a flush never leaves a stale word behind
    always_comb begin
        data_d  = load ? d : data_q;
        valid_d = clear ? 1'b0 : (load ? 1'b1 : valid_q);
    end

    // storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding fetch FSM and IF/ID pipeline register
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
    parameter logic [N-1:0] NOP      = N'(NOP_INSTR)
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [N-1:0]         redirect_pc,
    output logic                 id_valid,
    output logic [N-1:0]         id_instr,
    output logic [N-1:0]         id_pc,
    output logic [N-1:0]         id_pc_plus4
);

    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    fetch_state_e state_d, state_q;
    logic [N-1:0] pc_d, pc_q;
    logic         id_valid_d, id_valid_q;
    logic [N-1:0] id_instr_d, id_instr_q;
    logic [N-1:0] id_pc_d, id_pc_q;
    logic [N-1:0] id_pc_plus4_d, id_pc_plus4_q;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] buf_data;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_clear;
    logic         load;
    logic         take;
    logic [N-1:0] word;

    assign pc_plus4       = pc_q + N'(4);
    assign load           = !id_valid_q || !id_stall;
    assign imem.imem_req  = (state_q == S_REQ) && !redirect_valid;
    assign imem.imem_addr = pc_q & ALIGN_MASK;

    fetch_buffer #(.N(N)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .d     (imem.imem_rdata),
        .q     (buf_data),
        .valid (buf_valid)
    );

    // next-state for FSM, PC and IF/ID; redirect overrides stall and any arriving word
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        take          = 1'b0;
        word          = buf_data;
        if (redirect_valid) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            id_valid_d = 1'b0;
            id_instr_d = NOP;
            buf_clear  = 1'b1;
            state_d    = (state_q == S_WAIT && !imem.imem_rvalid) ? S_DROP : S_REQ;
        end else begin
            case (state_q)
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (imem.imem_rvalid && load) begin
                        take = 1'b1;
                        word = imem.imem_rdata;
                    end else if (imem.imem_rvalid) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    take      = load && buf_valid;
                    buf_clear = take;
                end
                S_DROP: state_d = imem.imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
            if (take) begin
                id_valid_d    = 1'b1;
                id_instr_d    = word;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_plus4;
                pc_d          = pc_plus4;
                state_d       = S_REQ;
            end else if (id_valid_q && !id_stall) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP;
            end
        end
    end

    // state, PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC & ALIGN_MASK;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP;
            id_pc_q       <= '0;
            id_pc_plus4_q <= N'(4);
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the pipelined RV32I core. Owns the PC, issues one word-aligned request at a time to instruction memory, and accepts responses of variable latency. Absorbs hazard-unit stalls with a one-entry holding buffer and applies branch/jump redirects from EX. Its `id_instr` output feeds decode and the immediate generator directly.

## Interface
- `N`, 32: datapath and instruction width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP`, 32'h0000_0013: `addi x0,x0,0`; value driven on `id_instr` whenever `id_valid`=0.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request strobe.
- `imem_addr` out N: request address; always equals `pc`, with bits [1:0]=00.
- `imem_rdata` in N: response instruction word.
- `imem_rvalid` in 1: response strobe.
  - Arrives at least 1 cycle after the accepted `imem_req`.
  - At most one response per request.
- `id_stall` in 1: hazard unit holds IF/ID.
- `redirect_valid` in 1: taken branch/jump from EX; also flushes IF/ID.
- `redirect_pc` in N: target address; bits [1:0] are forced to 00.
- `id_valid` out 1: IF/ID holds a live instruction.
- `id_instr` out N: IF/ID instruction.
- `id_pc` out N: PC of `id_instr`.
- `id_pc_plus4` out N: `id_pc`+4, mod 2^N.

## Operation
- FSM states:
  - REQ: issue request.
  - WAIT: request outstanding.
  - HOLD: response parked in the buffer.
  - DROP: discard one stale response.
- Only one request is ever outstanding.
- `imem_req` = (state==REQ) && !`redirect_valid`, combinational. Request accepted same cycle; no ready signal.
- `load` = !`id_valid` || !`id_stall`. This means IF/ID can take a new word this edge.
- REQ:
  - If `imem_req`=1, go to WAIT.
  - Otherwise stay in REQ.
- WAIT with `imem_rvalid`:
  - If `load`: IF/ID ← {1, `imem_rdata`, `pc`, `pc`+4}; `pc` ← `pc`+4; go to REQ.
  - Else: buf ← `imem_rdata`; go to HOLD. `pc` is unchanged.
- WAIT without `imem_rvalid`: stay in WAIT.
- HOLD:
  - If `load`: IF/ID ← {1, buf, `pc`, `pc`+4}; `pc` ← `pc`+4; go to REQ.
  - Otherwise stay in HOLD.
- DROP: on `imem_rvalid`, discard the word and go to REQ.
- When `id_valid`=1 and `id_stall`=0 and nothing loads this edge, `id_valid` ← 0 (bubble) and `id_instr` ← NOP.
- Redirect has priority over everything except `rst`:
  - Registers: `pc` ← {`redirect_pc`[N-1:2], 2'b00}; `id_valid` ← 0; `id_instr` ← NOP; buf is invalidated.
  - Next state from WAIT: DROP if `imem_rvalid`=0 this cycle, else REQ (the word arriving this cycle is discarded).
  - Next state from HOLD, REQ or DROP: REQ. In DROP, a response arriving this cycle is consumed.
  - Redirect overrides `id_stall` (flush beats stall).
- `pc`+4 wraps modulo 2^N; no fault is raised.
- `rst` mid-operation:
  - `pc` ← `RESET_PC`, state ← REQ, `id_valid` ← 0, `id_instr` ← NOP, `id_pc` ← 0, `id_pc_plus4` ← 4, buf invalid.
  - An in-flight memory response is not tracked; memory is reset by the same `rst`.

## Timing
- Reset values: `imem_req`=1 once `rst` deasserts (state REQ), `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=NOP, `id_pc`=0, `id_pc_plus4`=4.
- Latency: request at cycle t and `imem_rvalid` at t+L puts the instruction in IF/ID at edge t+L+1. The next request goes out at t+L+1.
- Peak throughput is 1 instruction per (L+1) cycles; with L=1 that is one every 2 cycles.
- Redirect at cycle t: first request to the target is issued at t+1, or later if a stale response is still pending (DROP).
- While `id_stall`=1 and `id_valid`=1, all `id_*` outputs hold exactly.

## Structure
- Shared package `riscv_pkg`: NOP encoding, `RESET_PC` default, fetch FSM state enum (2-bit).
- Sub-module `fetch_buffer` (one-entry data+valid holding register with load/clear) is natural.
- PC register, FSM and IF/ID register stay in `fetch_stage`.

## Test plan
- Reset, memory L=1 returning `imem_rdata`=addr|0x13: `id_pc` shows 0x0, 0x4, 0x8 on alternate cycles, `id_valid` pulses 1,0,1,0, `id_pc_plus4`=`id_pc`+4.
- `id_stall` held for 5 cycles while a response arrives: state goes to HOLD; `id_instr`/`id_pc` (0x8) are held; the buffered word (pc 0xC) is loaded on the first unstalled edge; no word is lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x100 while in WAIT, response at L=3: the stale word is dropped and `id_valid`=0. The next request has `imem_addr`=0x100, and the first valid `id_pc`=0x100.
- `redirect_valid` and `id_stall` together while `id_valid`=1: `id_valid`=0 and `id_instr`=0x00000013 the next cycle.
- `redirect_pc`=0x103: `imem_addr`=0x100.
- `RESET_PC`=0xFFFFFFFC: after the first fetch, `id_pc_plus4`=0 and the next `imem_addr`=0x0.
- `rst` asserted in HOLD: all outputs return to their reset values next cycle.
